regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parameterised multi-port register file, successor to the single-write/dual-read regfile. Provides RP asynchronous read ports and WP synchronous write ports. Register 0 is hardwired to zero. Carries a per-register busy scoreboard for hazard detection by the decode stage. Sits between decode (reads, reserve) and writeback (writes) in the pipelined core.

Parameters:
n, 32, data width in bits
r, 5, address width; depth = 2**r registers
RP, 2, number of read ports (>=1)
WP, 2, number of write ports (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-low
read_addr  input  RP*r  read addresses; port i = bits [i*r +: r]
read_data  output  RP*n  read data; port i = bits [i*n +: n]
read_busy  output  RP  scoreboard busy bit for each read address
write_en  input  WP  per-port write enable
write_addr  input  WP*r  write addresses; port j = bits [j*r +: r]
write_data  input  WP*n  write data; port j = bits [j*n +: n]
reserve_en  input  1  mark reserve_addr busy (destination issued)
reserve_addr  input  r  register to reserve
any_busy  output  1  OR of all busy bits

Behaviour:
- Reset: synchronous, active-low. On a rising clk edge with rst==0:
  - all 2**r registers are set to 0;
  - all busy bits are set to 0;
  - writes and reserves in that cycle are ignored.
- Outputs during and after reset: read_data = 0, read_busy = 0, any_busy = 0. Reset mid-operation discards all pending state.
- Reads: combinational, zero latency.
  - read_data[i] = mem[read_addr[i]].
  - Address 0 always reads 0 with busy = 0.
- Writes: on the rising edge, for each j with write_en[j]==1 and write_addr[j]!=0, mem[write_addr[j]] <= write_data[j]. Writes to address 0 are dropped.
- Write conflict: two ports writing the same address in one cycle resolve to the highest-index port.
- Scoreboard set: reserve_en with reserve_addr!=0 sets busy[reserve_addr] on the edge.
- Scoreboard clear: any enabled write to address k!=0 clears busy[k] on the edge.
- Reserve and write to the same address in the same cycle: reserve wins, busy stays 1, and data is still written.
- read_busy[i] = busy[read_addr[i]], registered state with no same-cycle bypass of reserve or clear.
- Write-then-read to the same address across cycles: the new value is visible the cycle after the edge.
- Same-cycle read of a written address returns the old value unless REGFILE_BYPASS_EN is defined.
- any_busy: combinational OR reduction of the busy vector.
- No X propagation: an unwritten register reads 0 after the first reset.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-through bypass.
  - If write_en[j] and write_addr[j]==read_addr[i]!=0, read_data[i] = write_data[j] in the same cycle, highest-index matching port taking priority.
  - read_busy[i] is forced to 0 in that case.
- Undefined: reads return array contents only (old value). No bypass muxing is generated.

Decomposition:
- Package regfile_pkg holds:
  - default constants REGFILE_N=32, REGFILE_R=5, REGFILE_RP=2, REGFILE_WP=2;
  - typedef reg_addr_t (logic [REGFILE_R-1:0]);
  - typedef reg_data_t (logic [REGFILE_N-1:0]).
- One natural sub-module, regfile_scoreboard: holds the busy vector with set/clear/priority logic and exposes busy bits and any_busy. Storage and read muxing stay in regfile_mp.

Test Plan:
1. Reset: hold rst=0 two cycles with write_en=2'b11 to addr 3 -> all read_data 0, any_busy 0, and addr 3 reads 0 after release.
2. Basic write/read: port0 writes 0xA7 to r6 -> next cycle read_addr[0]=6 gives 0xA7. Writing 0x55 to r0 -> r0 reads 0.
3. Write conflict: both ports write r5 in one cycle with data 0x11 (port0) and 0x22 (port1) -> r5 reads 0x22.
4. Scoreboard: reserve r7 -> read_busy=1 and any_busy=1 next cycle. Write r7=0x3C -> busy clears next cycle. Simultaneous reserve and write of r7 -> busy stays 1 and r7=new data.
5. Bypass: write r9=0x99 while reading r9 in the same cycle -> 0x99 with REGFILE_BYPASS_EN defined, old value 0 without it.
6. Reset mid-operation: with r2=0x23 and r4 busy, pulse rst=0 for one cycle -> r2 reads 0, busy cleared, and a concurrent write is ignored.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and typedefs for the multi-port register file.
package regfile_pkg;

    localparam int REGFILE_N  = 32;
    localparam int REGFILE_R  = 5;
    localparam int REGFILE_RP = 2;
    localparam int REGFILE_WP = 2;

    typedef logic [REGFILE_R-1:0] reg_addr_t;
    typedef logic [REGFILE_N-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reserve sets, any enabled write clears, reserve wins on collision.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int r  = REGFILE_R,
    parameter int WP = REGFILE_WP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WP-1:0]     write_en,
    input  logic [WP*r-1:0]   write_addr,
    input  logic              reserve_en,
    input  logic [r-1:0]      reserve_addr,
    output logic [(1<<r)-1:0] busy,
    output logic              any_busy
);

    localparam int DEPTH = 1 << r;

    logic [DEPTH-1:0] busy_next;

    always_comb begin
        busy_next = busy;
        for (int unsigned j = 0; j < WP; j++) begin
            if (write_en[j] && write_addr[j*r +: r] != '0)
                busy_next[write_addr[j*r +: r]] = 1'b0;
        end
        // Applied after the clears so a same-cycle reserve keeps the bit set.
        if (reserve_en && reserve_addr != '0)
            busy_next[reserve_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            busy <= '0;
        else
            busy <= busy_next;
    end

    assign any_busy = |busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file (RP async reads, WP sync writes, r0 hardwired zero) with busy scoreboard.
// Optional write-through read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int n  = REGFILE_N,
    parameter int r  = REGFILE_R,
    parameter int RP = REGFILE_RP,
    parameter int WP = REGFILE_WP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RP*r-1:0] read_addr,
    output logic [RP*n-1:0] read_data,
    output logic [RP-1:0]   read_busy,
    input  logic [WP-1:0]   write_en,
    input  logic [WP*r-1:0] write_addr,
    input  logic [WP*n-1:0] write_data,
    input  logic            reserve_en,
    input  logic [r-1:0]    reserve_addr,
    output logic            any_busy
);

    localparam int DEPTH = 1 << r;

    logic [n-1:0]     mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic             sb_any;

    regfile_scoreboard #(
        .r  (r),
        .WP (WP)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .write_en     (write_en),
        .write_addr   (write_addr),
        .reserve_en   (reserve_en),
        .reserve_addr (reserve_addr),
        .busy         (busy),
        .any_busy     (sb_any)
    );

    // Ascending port order makes the highest-index port's write land last.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned k = 0; k < DEPTH; k++)
                mem[k] <= '0;
        end else begin
            for (int unsigned j = 0; j < WP; j++) begin
                if (write_en[j] && write_addr[j*r +: r] != '0)
                    mem[write_addr[j*r +: r]] <= write_data[j*n +: n];
            end
        end
    end

    always_comb begin : read_mux
        logic [r-1:0] ra;
        logic [n-1:0] d;
        logic         b;
        read_data = '0;
        read_busy = '0;
        for (int unsigned i = 0; i < RP; i++) begin
            ra = read_addr[i*r +: r];
            d  = mem[ra];
            b  = busy[ra];
`ifdef REGFILE_BYPASS_EN
            for (int unsigned j = 0; j < WP; j++) begin
                if (write_en[j] && write_addr[j*r +: r] == ra) begin
                    d = write_data[j*n +: n];
                    b = 1'b0;
                end
            end
`endif
            if (ra == '0 || !rst) begin
                d = '0;
                b = 1'b0;
            end
            read_data[i*n +: n] = d;
            read_busy[i]        = b;
        end
    end

    assign any_busy = rst & sb_any;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed test-plan cases then random traffic vs an array model.
module tb_regfile_mp;

    localparam int N  = 32;
    localparam int R  = 5;
    localparam int RP = 2;
    localparam int WP = 2;
    localparam int DEPTH = 1 << R;

    logic            clk = 1'b0;
    logic            rst;
    logic [RP*R-1:0] read_addr;
    logic [RP*N-1:0] read_data;
    logic [RP-1:0]   read_busy;
    logic [WP-1:0]   write_en;
    logic [WP*R-1:0] write_addr;
    logic [WP*N-1:0] write_data;
    logic            reserve_en;
    logic [R-1:0]    reserve_addr;
    logic            any_busy;

    logic [R-1:0] ra [RP];
    logic [R-1:0] wa [WP];
    logic [N-1:0] wd [WP];

    always_comb begin
        for (int i = 0; i < RP; i++) read_addr[i*R +: R] = ra[i];
        for (int j = 0; j < WP; j++) begin
            write_addr[j*R +: R] = wa[j];
            write_data[j*N +: N] = wd[j];
        end
    end

    regfile_mp #(.n(N), .r(R), .RP(RP), .WP(WP)) dut (
        .clk          (clk),
        .rst          (rst),
        .read_addr    (read_addr),
        .read_data    (read_data),
        .read_busy    (read_busy),
        .write_en     (write_en),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .reserve_en   (reserve_en),
        .reserve_addr (reserve_addr),
        .any_busy     (any_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: register contents and busy flags.
    logic [N-1:0] m_mem  [DEPTH];
    bit           m_busy [DEPTH];

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] rd(input int i);
        logic [RP*N-1:0] v;
        v = read_data;
        return v[i*N +: N];
    endfunction

    task automatic check_outputs();
        logic [N-1:0] ed;
        bit           eb;
        bit           ea;
        ea = 0;
        for (int k = 0; k < DEPTH; k++) ea |= m_busy[k];
        for (int i = 0; i < RP; i++) begin
            ed = m_mem[ra[i]];
            eb = m_busy[ra[i]];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < WP; j++)
                if (write_en[j] && wa[j] == ra[i]) begin
                    ed = wd[j];
                    eb = 0;
                end
`endif
            if (ra[i] == 0 || !rst) begin
                ed = '0;
                eb = 0;
            end
            check($sformatf("rdata%0d@%0d", i, ra[i]), rd(i), ed);
            check($sformatf("rbusy%0d@%0d", i, ra[i]), {31'b0, read_busy[i]}, {31'b0, eb});
        end
        check("any_busy", {31'b0, any_busy}, {31'b0, (rst ? ea : 1'b0)});
    endtask

    task automatic model_edge();
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                m_mem[k]  = '0;
                m_busy[k] = 0;
            end
        end else begin
            for (int j = 0; j < WP; j++)
                if (write_en[j] && wa[j] != 0) begin
                    m_mem[wa[j]]  = wd[j];
                    m_busy[wa[j]] = 0;
                end
            if (reserve_en && reserve_addr != 0) m_busy[reserve_addr] = 1;
        end
    endtask

    task automatic cycle();
        #2;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        write_en   = '0;
        reserve_en = 1'b0;
        for (int j = 0; j < WP; j++) begin
            wa[j] = '0;
            wd[j] = '0;
        end
        reserve_addr = '0;
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            m_mem[k]  = '0;
            m_busy[k] = 0;
        end
        rst = 1'b0;
        idle();
        for (int i = 0; i < RP; i++) ra[i] = '0;
        @(posedge clk);
        #1;

        // 1: reset held two cycles while writing r3
        write_en = 2'b11; wa[0] = 3; wa[1] = 3; wd[0] = 32'h1; wd[1] = 32'h2;
        ra[0] = 3; ra[1] = 0;
        cycle();
        cycle();
        rst = 1'b1;
        idle();
        #1;
        check("rst_r3", rd(0), 32'h0);
        check("rst_any", {31'b0, any_busy}, 32'h0);
        cycle();

        // 2: basic write/read and r0 write dropped
        write_en = 2'b01; wa[0] = 6; wd[0] = 32'hA7;
        cycle();
        idle(); ra[0] = 6; #1;
        check("wr_r6", rd(0), 32'hA7);
        write_en = 2'b01; wa[0] = 0; wd[0] = 32'h55;
        cycle();
        idle(); ra[0] = 0; #1;
        check("wr_r0", rd(0), 32'h0);
        cycle();

        // 3: write conflict resolves to port 1
        write_en = 2'b11; wa[0] = 5; wa[1] = 5; wd[0] = 32'h11; wd[1] = 32'h22;
        cycle();
        idle(); ra[0] = 5; #1;
        check("conflict_r5", rd(0), 32'h22);
        cycle();

        // 4: scoreboard set, clear, reserve-vs-write
        reserve_en = 1'b1; reserve_addr = 7;
        ra[1] = 7;
        cycle();
        idle(); #1;
        check("sb_set", {31'b0, read_busy[1]}, 32'h1);
        check("sb_any", {31'b0, any_busy}, 32'h1);
        write_en = 2'b01; wa[0] = 7; wd[0] = 32'h3C;
        cycle();
        idle(); #1;
        check("sb_clr", {31'b0, read_busy[1]}, 32'h0);
        check("sb_r7", rd(1), 32'h3C);
        write_en = 2'b10; wa[1] = 7; wd[1] = 32'h5A; reserve_en = 1'b1; reserve_addr = 7;
        cycle();
        idle(); #1;
        check("sb_keep", {31'b0, read_busy[1]}, 32'h1);
        check("sb_newdata", rd(1), 32'h5A);
        cycle();

        // 5: same-cycle read of a written register
        ra[0] = 9; write_en = 2'b01; wa[0] = 9; wd[0] = 32'h99;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_r9", rd(0), 32'h99);
`else
        check("bypass_r9", rd(0), 32'h0);
`endif
        cycle();
        idle();

        // 6: reset mid-operation
        write_en = 2'b01; wa[0] = 2; wd[0] = 32'h23; reserve_en = 1'b1; reserve_addr = 4;
        cycle();
        idle(); ra[0] = 2; ra[1] = 4;
        rst = 1'b0; write_en = 2'b01; wa[0] = 2; wd[0] = 32'h77;
        cycle();
        rst = 1'b1; idle(); #1;
        check("midrst_r2", rd(0), 32'h0);
        check("midrst_busy", {31'b0, read_busy[1]}, 32'h0);
        check("midrst_any", {31'b0, any_busy}, 32'h0);
        cycle();

        // Random traffic over a narrow address window to force collisions
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) != 0);
            for (int i = 0; i < RP; i++) ra[i] = R'($urandom_range(0, 11));
            for (int j = 0; j < WP; j++) begin
                write_en[j] = ($urandom_range(0, 2) != 0);
                wa[j] = R'($urandom_range(0, 11));
                wd[j] = $urandom;
            end
            reserve_en   = ($urandom_range(0, 2) == 0);
            reserve_addr = R'($urandom_range(0, 11));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
